// File: rtl/bus_arb_pkg.sv
// Shared types and IDs for the split-capable bus arbiter.
// Imported by the arbiter top and its split tracker.
package bus_arb_pkg;

    localparam int SLAVE_SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;

    localparam logic [SLAVE_SEL_W-1:0] SLV_NONE = 2'd0;
    localparam logic [SLAVE_SEL_W-1:0] SLV_4K1  = 2'd1;
    localparam logic [SLAVE_SEL_W-1:0] SLV_4K2  = 2'd2;
    localparam logic [SLAVE_SEL_W-1:0] SLV_2K   = 2'd3;

endpackage

// File: rtl/bus_arbiter_split_tracker.sv
// Per-master split bookkeeping: parked flag, parked slave ID and
// resume flag, plus the "slave held by the other master" query.
module split_tracker
    import bus_arb_pkg::*;
#(
    parameter int SEL_W      = SLAVE_SEL_W,
    parameter int NUM_SLAVES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic                  set_mst,
    input  logic [SEL_W-1:0]      set_id,
    input  logic                  clr_en,
    input  logic                  clr_mst,
    input  logic [NUM_SLAVES-1:0] split_resume,
    input  logic [SEL_W-1:0]      m1_sel,
    input  logic [SEL_W-1:0]      m2_sel,
    output logic [1:0]            split_flag,
    output logic [1:0]            resume_flag,
    output logic                  m1_blocked,
    output logic                  m2_blocked
);

    logic [1:0]            flag_q, flag_d;
    logic [1:0]            res_q, res_d;
    logic [1:0][SEL_W-1:0] id_q, id_d;

    // Resume only lands on a master already parked on that slave;
    // a new split wins over an old state, a grant clears everything.
    always_comb begin
        flag_d = flag_q;
        res_d  = res_q;
        id_d   = id_q;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (split_resume[k] && flag_q[m] &&
                    id_q[m] == SEL_W'(k + 1)) begin
                    res_d[m] = 1'b1;
                end
            end
        end
        if (set_en) begin
            flag_d[set_mst] = 1'b1;
            id_d[set_mst]   = set_id;
            res_d[set_mst]  = 1'b0;
        end
        if (clr_en) begin
            flag_d[clr_mst] = 1'b0;
            id_d[clr_mst]   = '0;
            res_d[clr_mst]  = 1'b0;
        end
    end

    // Split state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= '0;
            res_q  <= '0;
            id_q   <= '0;
        end else begin
            flag_q <= flag_d;
            res_q  <= res_d;
            id_q   <= id_d;
        end
    end

    // A slave parked by one master is off-limits to the other.
    always_comb begin
        m1_blocked = flag_q[M2] && (id_q[M2] == m1_sel);
        m2_blocked = flag_q[M1] && (id_q[M1] == m2_sel);
    end

    assign split_flag  = flag_q;
    assign resume_flag = res_q;

endmodule

// File: rtl/bus_arbiter_split.sv
// Round-robin two-master bus arbiter with split transactions,
// abort handling and a hold timeout.
module bus_arbiter_split
    import bus_arb_pkg::*;
#(
    parameter int SLAVE_SEL_W = bus_arb_pkg::SLAVE_SEL_W,
    parameter int NUM_SLAVES  = 3,
    parameter int TIMEOUT     = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m1_request,
    input  logic                   m2_request,
    input  logic [SLAVE_SEL_W-1:0] m1_slave_sel,
    input  logic [SLAVE_SEL_W-1:0] m2_slave_sel,
    input  logic                   trans_done,
    input  logic                   split_req,
    input  logic [NUM_SLAVES-1:0]  split_resume,
    output logic                   m1_grant,
    output logic                   m2_grant,
    output logic                   m1_split,
    output logic                   m2_split,
    output logic                   master_route,
    output logic [SLAVE_SEL_W-1:0] slave_route,
    output logic                   busy,
    output logic                   bus_busy,
    output logic                   timeout
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    logic                   route_q, route_d;
    logic [SLAVE_SEL_W-1:0] slv_q, slv_d;
    logic                   last_q, last_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic                   tout_q, tout_d;

    logic       split_set;
    logic       grant_en;
    logic       win;
    logic       m1_elig;
    logic       m2_elig;
    logic       m1_blocked;
    logic       m2_blocked;
    logic       owner_req;
    logic [1:0] split_flag;
    logic [1:0] resume_flag;

    function automatic logic sel_ok(input logic [SLAVE_SEL_W-1:0] s);
        return (s != '0) && (int'(s) <= NUM_SLAVES);
    endfunction

    split_tracker #(
        .SEL_W      (SLAVE_SEL_W),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_split (
        .clk          (clk),
        .reset        (reset),
        .set_en       (split_set),
        .set_mst      (route_q),
        .set_id       (slv_q),
        .clr_en       (grant_en),
        .clr_mst      (win),
        .split_resume (split_resume),
        .m1_sel       (m1_slave_sel),
        .m2_sel       (m2_slave_sel),
        .split_flag   (split_flag),
        .resume_flag  (resume_flag),
        .m1_blocked   (m1_blocked),
        .m2_blocked   (m2_blocked)
    );

    // Who may take the bus this cycle.
    always_comb begin
        m1_elig = m1_request && sel_ok(m1_slave_sel) &&
                  (!split_flag[M1] || resume_flag[M1]) && !m1_blocked;
        m2_elig = m2_request && sel_ok(m2_slave_sel) &&
                  (!split_flag[M2] || resume_flag[M2]) && !m2_blocked;
        owner_req = (route_q == M2) ? m2_request : m1_request;
    end

    // Winner pick: resumed master first, else the one not granted last.
    always_comb begin
        win = M1;
        if (m1_elig && m2_elig) begin
            if (resume_flag[M1] != resume_flag[M2]) begin
                win = resume_flag[M2] ? M2 : M1;
            end else begin
                win = (last_q == M1) ? M2 : M1;
            end
        end else if (m2_elig) begin
            win = M2;
        end
    end

    // Next-state logic for arbitration, ownership and release.
    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        slv_d     = slv_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tout_d    = 1'b0;
        grant_en  = 1'b0;
        split_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m1_elig || m2_elig) begin
                    grant_en = 1'b1;
                    state_d  = OWN;
                    route_d  = win;
                    slv_d    = (win == M2) ? m2_slave_sel : m1_slave_sel;
                    last_d   = win;
                    cnt_d    = '0;
                end
            end
            OWN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (trans_done) begin
                    state_d = RELEASE;
                end else if (split_req) begin
                    state_d   = RELEASE;
                    split_set = 1'b1;
                end else if (!owner_req) begin
                    state_d = RELEASE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = RELEASE;
                    tout_d  = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            route_q <= M1;
            slv_q   <= SLV_NONE;
            last_q  <= M2;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            slv_q   <= slv_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        bus_busy     = (state_q == OWN);
        busy         = (state_q != IDLE);
        m1_grant     = bus_busy && (route_q == M1);
        m2_grant     = bus_busy && (route_q == M2);
        master_route = bus_busy && route_q;
        slave_route  = bus_busy ? slv_q : SLV_NONE;
        m1_split     = split_flag[M1];
        m2_split     = split_flag[M2];
        timeout      = tout_q;
    end

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Scoreboard bench for bus_arbiter_split: scripted scenarios push
// expected output bundles per cycle; a negedge monitor pops them.
module tb_bus_arbiter_split;

    logic       clk = 1'b0;
    logic       reset;
    logic       m1_request, m2_request;
    logic [1:0] m1_slave_sel, m2_slave_sel;
    logic       trans_done, split_req;
    logic [2:0] split_resume;
    logic       m1_grant, m2_grant, m1_split, m2_split;
    logic       master_route, busy, bus_busy, timeout;
    logic [1:0] slave_route;

    int n_run  = 0;
    int n_fail = 0;
    int t      = -1;

    typedef struct {
        int         t;
        string      tag;
        logic [9:0] exp;
    } sb_t;

    sb_t sb[$];
    sb_t e;

    bus_arbiter_split dut (
        .clk          (clk),
        .reset        (reset),
        .m1_request   (m1_request),
        .m2_request   (m2_request),
        .m1_slave_sel (m1_slave_sel),
        .m2_slave_sel (m2_slave_sel),
        .trans_done   (trans_done),
        .split_req    (split_req),
        .split_resume (split_resume),
        .m1_grant     (m1_grant),
        .m2_grant     (m2_grant),
        .m1_split     (m1_split),
        .m2_split     (m2_split),
        .master_route (master_route),
        .slave_route  (slave_route),
        .busy         (busy),
        .bus_busy     (bus_busy),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    wire [9:0] outv = {m1_grant, m2_grant, m1_split, m2_split,
                       master_route, slave_route, busy, bus_busy,
                       timeout};

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Field order: g1 g2 s1 s2 mr sr[1:0] busy bb to
    function automatic logic [9:0] own1(input logic [1:0] sr,
                                        input logic s1,
                                        input logic s2);
        return {1'b1, 1'b0, s1, s2, 1'b0, sr, 1'b1, 1'b1, 1'b0};
    endfunction

    function automatic logic [9:0] own2(input logic [1:0] sr,
                                        input logic s1,
                                        input logic s2);
        return {1'b0, 1'b1, s1, s2, 1'b1, sr, 1'b1, 1'b1, 1'b0};
    endfunction

    function automatic logic [9:0] rel(input logic s1, input logic s2,
                                       input logic to);
        return {2'b00, s1, s2, 1'b0, 2'b00, 1'b1, 1'b0, to};
    endfunction

    function automatic logic [9:0] idl(input logic s1, input logic s2);
        return {2'b00, s1, s2, 6'b000000};
    endfunction

    task automatic ex(input string s, input int tt, input logic [9:0] v);
        sb_t x;
        x.t   = tt;
        x.tag = $sformatf("%s_t%0d", s, tt);
        x.exp = v;
        sb.push_back(x);
    endtask

    task automatic go(input int n);
        while (t < n) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic clr_in();
        m1_request   = 1'b0;
        m2_request   = 1'b0;
        m1_slave_sel = 2'd0;
        m2_slave_sel = 2'd0;
        trans_done   = 1'b0;
        split_req    = 1'b0;
        split_resume = 3'b000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_in();
        t = -1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
    endtask

    task automatic drain(input string s);
        chk({s, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    // Compare every scheduled bundle; also the grant one-hot rule.
    always @(negedge clk) begin
        if (t >= 0) begin
            chk("onehot", {31'd0, m1_grant & m2_grant}, 0);
            while (sb.size() > 0 && sb[0].t == t) begin
                e = sb.pop_front();
                chk(e.tag, {22'd0, outv}, {22'd0, e.exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr_in();

        // Tie after reset, completion, round-robin handover.
        do_reset();
        ex("A", 0, idl(0, 0));
        ex("A", 1, own1(2'd1, 0, 0));
        ex("A", 5, own1(2'd1, 0, 0));
        ex("A", 6, rel(0, 0, 0));
        ex("A", 7, idl(0, 0));
        ex("A", 8, own2(2'd3, 0, 0));
        ex("A", 11, rel(0, 0, 0));
        ex("A", 12, idl(0, 0));
        m1_request = 1'b1; m1_slave_sel = 2'd1;
        m2_request = 1'b1; m2_slave_sel = 2'd3;
        go(5);  trans_done = 1'b1;
        go(6);  trans_done = 1'b0; m1_request = 1'b0;
        go(10); trans_done = 1'b1;
        go(11); trans_done = 1'b0; m2_request = 1'b0;
        go(13);
        drain("A");

        // Split, other master served, resume, parked master back first.
        do_reset();
        ex("B", 0, idl(0, 0));
        ex("B", 1, own1(2'd3, 0, 0));
        ex("B", 5, rel(1, 0, 0));
        ex("B", 6, idl(1, 0));
        ex("B", 7, own2(2'd1, 1, 0));
        ex("B", 9, own2(2'd1, 1, 0));
        ex("B", 10, rel(1, 0, 0));
        ex("B", 11, idl(1, 0));
        ex("B", 12, own1(2'd3, 0, 0));
        ex("B", 15, rel(0, 0, 0));
        ex("B", 16, idl(0, 0));
        ex("B", 17, own2(2'd1, 0, 0));
        ex("B", 19, rel(0, 0, 0));
        ex("B", 20, idl(0, 0));
        m1_request = 1'b1; m1_slave_sel = 2'd3;
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        go(4);  split_req = 1'b1;
        go(5);  split_req = 1'b0;
        go(8);  split_resume = 3'b100;
        go(9);  split_resume = 3'b000; trans_done = 1'b1;
        go(10); trans_done = 1'b0;
        go(14); trans_done = 1'b1;
        go(15); trans_done = 1'b0; m1_request = 1'b0;
        go(18); trans_done = 1'b1;
        go(19); trans_done = 1'b0; m2_request = 1'b0;
        go(21);
        drain("B");

        // Blocked slave, ignored resumes, then proper resume.
        do_reset();
        ex("C", 0, idl(0, 0));
        ex("C", 1, own1(2'd3, 0, 0));
        ex("C", 4, rel(1, 0, 0));
        ex("C", 5, idl(1, 0));
        ex("C", 8, idl(1, 0));
        ex("C", 10, idl(1, 0));
        ex("C", 11, own1(2'd3, 0, 0));
        ex("C", 13, rel(0, 0, 0));
        ex("C", 14, idl(0, 0));
        ex("C", 15, own2(2'd3, 0, 0));
        ex("C", 17, rel(0, 0, 0));
        ex("C", 18, idl(0, 0));
        m1_request = 1'b1; m1_slave_sel = 2'd3;
        go(3);  split_req = 1'b1; split_resume = 3'b100;
        go(4);  split_req = 1'b0; split_resume = 3'b000;
        m2_request = 1'b1; m2_slave_sel = 2'd3;
        go(6);  split_resume = 3'b001;
        go(7);  split_resume = 3'b000;
        go(9);  split_resume = 3'b100;
        go(10); split_resume = 3'b000;
        go(12); trans_done = 1'b1;
        go(13); trans_done = 1'b0; m1_request = 1'b0;
        go(16); trans_done = 1'b1;
        go(17); trans_done = 1'b0; m2_request = 1'b0;
        go(19);
        drain("C");

        // Hold timeout forces release; waiting master follows.
        do_reset();
        ex("D", 0, idl(0, 0));
        ex("D", 1, own2(2'd2, 0, 0));
        ex("D", 255, own2(2'd2, 0, 0));
        ex("D", 256, rel(0, 0, 1));
        ex("D", 257, idl(0, 0));
        ex("D", 258, own1(2'd1, 0, 0));
        ex("D", 261, rel(0, 0, 0));
        ex("D", 262, idl(0, 0));
        m2_request = 1'b1; m2_slave_sel = 2'd2;
        go(2);   m1_request = 1'b1; m1_slave_sel = 2'd1;
        go(256); m2_request = 1'b0;
        go(260); trans_done = 1'b1;
        go(261); trans_done = 1'b0; m1_request = 1'b0;
        go(263);
        drain("D");

        // Done+split together, resume priority, abort, reset mid-OWN.
        do_reset();
        ex("E", 0, idl(0, 0));
        ex("E", 1, own1(2'd2, 0, 0));
        ex("E", 3, own1(2'd2, 0, 0));
        ex("E", 4, rel(0, 0, 0));
        ex("E", 5, idl(0, 0));
        ex("E", 7, own1(2'd3, 0, 0));
        ex("E", 10, rel(1, 0, 0));
        ex("E", 11, idl(1, 0));
        ex("E", 12, own1(2'd3, 0, 0));
        ex("E", 15, rel(0, 0, 0));
        ex("E", 16, idl(0, 0));
        ex("E", 17, own2(2'd1, 0, 0));
        ex("E", 20, idl(0, 0));
        ex("E", 21, own1(2'd1, 0, 0));
        m1_request = 1'b1; m1_slave_sel = 2'd2;
        go(3);  trans_done = 1'b1; split_req = 1'b1;
        go(4);  trans_done = 1'b0; split_req = 1'b0; m1_request = 1'b0;
        go(6);  m1_request = 1'b1; m1_slave_sel = 2'd3;
        go(9);  split_req = 1'b1;
        go(10); split_req = 1'b0; split_resume = 3'b100;
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        go(11); split_resume = 3'b000;
        go(14); m1_request = 1'b0;
        go(19); reset = 1'b1;
        go(20); reset = 1'b0; m1_request = 1'b1; m1_slave_sel = 2'd1;
        go(22);
        drain("E");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
